// File: rtl/ksa.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ksa : ARC4 key-scheduling stage, permutes the 256x8 S RAM in place.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module ksa #(
  parameter int KEY_LEN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 rdy,
  input  logic [8*KEY_LEN-1:0] key,
  output logic [7:0]           addr,
  input  logic [7:0]           rddata,
  output logic [7:0]           wrdata,
  output logic                 wren
);

  localparam int c_kiw = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [c_kiw-1:0] c_klast = c_kiw'(KEY_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_I  = 3'd1,
    S_CAP_I = 3'd2,
    S_RD_J  = 3'd3,
    S_CAP_J = 3'd4,
    S_WR_I  = 3'd5,
    S_WR_J  = 3'd6
  } state_t;

  state_t               r_state;
  logic [7:0]           r_i;
  logic [7:0]           r_j;
  logic [7:0]           r_si;
  logic [8*KEY_LEN-1:0] r_key;
  logic [c_kiw-1:0]     r_kidx;

  logic [7:0] w_kbytes [KEY_LEN];
  logic [7:0] w_kbyte;
  logic [7:0] w_jnext;

  // Byte 0 of the key schedule is the most significant key byte.
  generate
    for (genvar g = 0; g < KEY_LEN; g++) begin : g_kbyte
      assign w_kbytes[g] = r_key[8*(KEY_LEN-1-g) +: 8];
    end
  endgenerate

  // r_kidx tracks i mod KEY_LEN so no divider is needed.
  assign w_kbyte = w_kbytes[r_kidx];
  assign w_jnext = r_j + rddata + w_kbyte;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      rdy     <= 1'b1;
      wren    <= 1'b0;
      addr    <= 8'd0;
      wrdata  <= 8'd0;
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_si    <= 8'd0;
      r_kidx  <= '0;
      r_key   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          wren <= 1'b0;
          if (en) begin
            r_key   <= key;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_kidx  <= '0;
            addr    <= 8'd0;
            rdy     <= 1'b0;
            r_state <= S_RD_I;
          end
        end
        S_RD_I: begin
          r_state <= S_CAP_I;
        end
        S_CAP_I: begin
          r_si    <= rddata;
          r_j     <= w_jnext;
          addr    <= w_jnext;
          r_state <= S_RD_J;
        end
        S_RD_J: begin
          r_state <= S_CAP_J;
        end
        S_CAP_J: begin
          addr    <= r_i;
          wrdata  <= rddata;
          wren    <= 1'b1;
          r_state <= S_WR_I;
        end
        S_WR_I: begin
          addr    <= r_j;
          wrdata  <= r_si;
          r_state <= S_WR_J;
        end
        S_WR_J: begin
          wren   <= 1'b0;
          addr   <= r_i + 8'd1;
          r_kidx <= (r_kidx == c_klast) ? '0 : r_kidx + 1'b1;
          if (r_i == 8'hff) begin
            rdy     <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_i     <= r_i + 8'd1;
            r_state <= S_RD_I;
          end
        end
        default: begin
          wren    <= 1'b0;
          rdy     <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ksa.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ksa : scoreboard bench for ksa against a plain-arithmetic ARC4 KSA model.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;
  logic        ram_init;

  logic [7:0]  mem  [256];
  logic [7:0]  gimg [256];
  logic [15:0] expq [$];
  logic [15:0] wlog [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  ksa #(.KEY_LEN(3)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
    .addr(addr), .rddata(rddata), .wrdata(wrdata), .wren(wren)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // S RAM: synchronous 1-cycle read, read-before-write
  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= k[7:0];
    end else begin
      rddata <= mem[addr];
      if (wren) mem[addr] <= wrdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write cycle pops one expected (addr,data) pair.
  always @(negedge clk) begin
    if (wren === 1'b1) begin
      wlog.push_back({addr, wrdata});
      if (expq.size() == 0) begin
        check("unexpected_write", {16'd0, addr, wrdata}, 32'hffffffff);
      end else begin
        logic [15:0] e;
        e = expq.pop_front();
        check("write_addr_data", {16'd0, addr, wrdata}, {16'd0, e});
      end
    end
  end

  // Reference: textbook ARC4 KSA over the bench's image of S.
  task automatic golden(input logic [23:0] k);
    int j;
    logic [7:0] t;
    logic [7:0] kb;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = k[8*(2-(i%3)) +: 8];
      j = (j + int'(gimg[i]) + int'(kb)) % 256;
      expq.push_back({i[7:0], gimg[j]});
      expq.push_back({j[7:0], gimg[i]});
      t = gimg[i];
      gimg[i] = gimg[j];
      gimg[j] = t;
    end
  endtask

  task automatic reinit_ram();
    @(posedge clk); #1;
    ram_init = 1'b1;
    @(posedge clk); #1;
    ram_init = 1'b0;
    for (int k = 0; k < 256; k++) gimg[k] = k[7:0];
  endtask

  task automatic start(input logic [23:0] k);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rdy_before_start", {31'd0, rdy}, 32'd1);
    en = 1'b1;
    key = k;
    wlog.delete();
    golden(k);
    @(posedge clk); #1;
    t0 = cyc;
    en = 1'b0;
    key = 24'($urandom);
    check("rdy_low_after_accept", {31'd0, rdy}, 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", cyc - t0, 32'd1536);
  endtask

  task automatic check_ram(input string name);
    int bad;
    bad = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 256; k++) if (mem[k] !== gimg[k]) bad++;
    check(name, bad, 0);
    check("queue_drained", expq.size(), 0);
  endtask

  initial begin
    logic [15:0] t1exp [6];
    logic [23:0] rk;
    int n;

    rst = 1'b1; en = 1'b0; key = 24'd0; ram_init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy", {31'd0, rdy}, 32'd1);
    check("reset_wren", {31'd0, wren}, 32'd0);
    check("reset_addr", {24'd0, addr}, 32'd0);
    check("reset_wrdata", {24'd0, wrdata}, 32'd0);
    rst = 1'b0;
    ram_init = 1'b0;
    for (int k = 0; k < 256; k++) gimg[k] = k[7:0];

    // T1: all-zero key, known opening write sequence
    t1exp[0] = 16'h0000; t1exp[1] = 16'h0000; t1exp[2] = 16'h0101;
    t1exp[3] = 16'h0101; t1exp[4] = 16'h0203; t1exp[5] = 16'h0302;
    start(24'h000000);
    wait_done();
    check_ram("t1_ram");
    for (int w = 0; w < 6; w++)
      check("t1_early_write", {16'd0, (wlog.size() > w) ? wlog[w] : 16'hxxxx}, {16'd0, t1exp[w]});

    // T2 + T3: key 010203 on fresh RAM
    reinit_ram();
    start(24'h010203);
    wait_done();
    check_ram("t2_ram");
    check("t2_write_count", wlog.size(), 512);
    check("t2_first_write", {16'd0, (wlog.size() > 1) ? wlog[0] : 16'hxxxx}, 32'h0001);
    check("t2_second_write", {16'd0, (wlog.size() > 1) ? wlog[1] : 16'hxxxx}, 32'h0100);

    // T4: en with another key during a run is ignored
    reinit_ram();
    start(24'hA5C3_0F);
    repeat (300) @(posedge clk);
    #1;
    en = 1'b1; key = 24'h123456;
    @(posedge clk); #1;
    en = 1'b0;
    check("t4_still_busy", {31'd0, rdy}, 32'd0);
    wait_done();
    check_ram("t4_ram");

    // T5: reset in the middle of a run
    start(24'h3C_5A_99);
    repeat (700) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rdy", {31'd0, rdy}, 32'd1);
    check("t5_wren", {31'd0, wren}, 32'd0);
    check("t5_addr", {24'd0, addr}, 32'd0);
    rst = 1'b0;
    expq.delete();
    @(negedge clk);
    check("t5_no_write_after_rst", {31'd0, wren}, 32'd0);
    reinit_ram();
    start(24'hBEEF01);
    wait_done();
    check_ram("t5_ram");

    // T6: en held high restarts immediately on the permuted RAM with the current key
    @(negedge clk);
    en = 1'b1;
    key = 24'h0A0B0C;
    golden(24'h0A0B0C);
    @(posedge clk); #1;
    t0 = cyc;
    check("t6_rdy_low", {31'd0, rdy}, 32'd0);
    key = 24'hF00D42;
    n = 0;
    while (rdy !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_latency1", cyc - t0, 32'd1536);
    golden(24'hF00D42);
    @(posedge clk); #1;
    t0 = cyc;
    en = 1'b0;
    check("t6_restarted", {31'd0, rdy}, 32'd0);
    wait_done();
    check_ram("t6_ram");

    // Random keys chained on the current RAM contents
    for (int r = 0; r < 3; r++) begin
      rk = 24'($urandom);
      start(rk);
      wait_done();
      check_ram("rand_ram");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
